matmul_seq_ctrl: RTL
====================

# matmul_seq_ctrl

Sequencing controller for the 2x2 signed matrix multiplier. It accepts one packed A/B operand pair through a valid/ready handshake and time-shares a single internal multiply-accumulate unit across the eight partial products. It then streams the four C elements out through a valid/ready interface. It sits between the tile's pin-level input registers and the output mux, and replaces the fully parallel combinational array.

## Interface
- No parameters; element width is fixed at 2-bit two's complement (-2..1) and result width at 5-bit signed, sign-extended to 8.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present on a_in/b_in
- in_ready  out  1  controller can accept an operand pair
- a_in  in  8  matrix A packed {a11,a10,a01,a00}, 2 bits each, a00 in [1:0]
- b_in  in  8  matrix B packed {b11,b10,b01,b00}, same packing
- c_valid  out  1  c_data/c_idx hold a valid result element
- c_ready  in  1  consumer accepts element
- c_data  out  8  C element, 5-bit signed result sign-extended to 8 bits
- c_idx  out  2  element index {i,j}: 0=C00, 1=C01, 2=C10, 3=C11
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the C11 handshake
- abort  in  1  present only with MMSEQ_ABORT_EN (see Configuration)

## Operation
- FSM states: IDLE, MAC0, MAC1, EMIT.
- IDLE: in_ready=1. On in_valid&in_ready, capture a_in/b_in into operand registers, set idx=0, go to MAC0.
- MAC0: acc <= a[i][0]*b[0][j] (clears the accumulator). Go to MAC1.
- MAC1: acc <= acc + a[i][1]*b[1][j]. Go to EMIT.
- EMIT: c_valid=1, c_data={{3{acc[4]}},acc}, c_idx=idx.
  - On c_ready with idx<3: idx++, go to MAC0.
  - On c_ready with idx==3: go to IDLE and pulse done.
  - Without c_ready: hold state and hold all outputs stable.
- Arithmetic: products are 4-bit signed in the range -2..4. The sum is 5-bit signed in the range -4..8, so overflow cannot occur.
- Operand registers are only written in IDLE. in_valid while busy is ignored and in_ready stays 0.
- Output order is always C00, C01, C10, C11.
- Reset (at any state, including mid-EMIT) gives: state=IDLE, in_ready=1, c_valid=0, c_data=0, c_idx=0, busy=0, done=0, acc=0, idx=0, operand regs=0.

## Timing
- Edge E0 is the accept handshake. Then:
  - MAC0 during cycle E0–E1.
  - MAC1 during cycle E1–E2.
  - c_valid is high from E2.
- First result latency is 2 cycles after the accept edge. Each element takes 3 cycles minimum.
- With c_ready held at 1, the element handshakes occur at E3, E6, E9 and E12. done is high for the cycle E12–E13, and in_ready is high in that same cycle. The next accept can therefore occur at E13.
- Each cycle of c_ready low in EMIT stretches the sequence by exactly 1 cycle.
- done never coincides with c_valid.

## Configuration
- MMSEQ_ABORT_EN defined: adds the abort input.
  - abort=1 in any non-IDLE state returns the FSM to IDLE on the next edge, with c_valid=0 and done=0. No further elements are emitted. Operand registers are retained.
  - abort in IDLE has no effect.
  - abort takes priority over the c_ready handshake in the same cycle.
- MMSEQ_ABORT_EN undefined: no abort port, and the sequence always runs to completion or to rst.

## Test plan
- Reset: assert rst for 2 cycles mid-sequence (in EMIT, idx=1) -> next cycle c_valid=0, in_ready=1, busy=0, c_data=0x00, c_idx=0.
- Basic: a_in=8'b10_11_01_01 (A=[[1,1],[-1,-2]]), b_in=8'b01_11_00_01 (B=[[1,0],[-1,1]]), c_ready=1 -> c_data 0x00, 0x01, 0x01, 0xFE with c_idx 0,1,2,3 at handshakes E3/E6/E9/E12, then done at E12–E13.
- Extremes: a_in=b_in=8'hAA (all -2) -> all four elements 0x08; a_in=8'h55 (all 1), b_in=8'hAA -> all four elements 0xFC.
- Backpressure: same stimulus as Basic with c_ready=0 for 4 cycles during C01 -> c_data stays 0x01 and c_idx stays 1, stable; C11 handshake at E16; no element dropped or duplicated.
- Busy ignore: drive in_valid with new operands during MAC1 of the first element -> in_ready=0 and the results match the original operands. Back-to-back: the second pair is accepted in the done cycle, and its first c_valid follows 2 cycles later.
- MMSEQ_ABORT_EN: abort in EMIT of C10 with c_ready=1 -> no C10 handshake, IDLE next cycle, done never asserts.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// Sequential 2x2 signed matrix multiply controller: one shared MAC, results streamed C00..C11.
// Optional abort input enabled by defining MMSEQ_ABORT_EN.
`timescale 1ns/1ps
module matmul_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       c_valid,
  input  logic       c_ready,
`ifdef MMSEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic [7:0] c_data,
  output logic [1:0] c_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC0 = 2'd1,
    S_MAC1 = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  // Product a[i][k]*b[k][j] for element idx={i,j}, sign-extended to the accumulator width
  function automatic logic [4:0] elem_prod(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] idx, input logic k);
    logic [1:0] w_ae;
    logic [1:0] w_be;
    logic [3:0] w_p;
    w_ae = a[{idx[1], k, 1'b0} +: 2];
    w_be = b[{k, idx[0], 1'b0} +: 2];
    w_p  = {{2{w_ae[1]}}, w_ae} * {{2{w_be[1]}}, w_be};
    return {w_p[3], w_p};
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [4:0]  r_acc;
  logic [1:0]  r_idx;
  logic        r_in_ready;
  logic        r_c_valid;
  logic        r_busy;
  logic        r_done;
  logic        w_abort;
  logic        w_accept;
  logic        w_emit_hs;
  logic        w_last;
  logic [4:0]  w_prod;

`ifdef MMSEQ_ABORT_EN
  assign w_abort = abort & (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Next-state decode; abort overrides the output handshake
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_emit_hs    = 1'b0;
    w_last       = 1'b0;
    w_prod       = elem_prod(r_a, r_b, r_idx, r_state == S_MAC1);
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_MAC0;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_MAC0: w_next_state = S_MAC1;
      S_MAC1: w_next_state = S_EMIT;
      S_EMIT: begin
        if (c_ready) begin
          w_emit_hs = 1'b1;
          if (r_idx == 2'd3) begin
            w_last       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_MAC0;
          end
        end else begin
          w_next_state = S_EMIT;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_abort) begin
      w_next_state = S_IDLE;
      w_emit_hs    = 1'b0;
      w_last       = 1'b0;
    end else begin
      w_next_state = w_next_state;
    end
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= 8'd0;
      r_b        <= 8'd0;
      r_acc      <= 5'd0;
      r_idx      <= 2'd0;
      r_in_ready <= 1'b1;
      r_c_valid  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == S_IDLE);
      r_c_valid  <= (w_next_state == S_EMIT);
      r_busy     <= (w_next_state != S_IDLE);
      r_done     <= w_last;
      if (w_accept) begin
        r_a   <= a_in;
        r_b   <= b_in;
        r_idx <= 2'd0;
      end else if (w_emit_hs && !w_last) begin
        r_idx <= r_idx + 2'd1;
      end else begin
        r_idx <= r_idx;
      end
      if (r_state == S_MAC0 && !w_abort) begin
        r_acc <= w_prod;
      end else if (r_state == S_MAC1 && !w_abort) begin
        r_acc <= r_acc + w_prod;
      end else begin
        r_acc <= r_acc;
      end
    end
  end

  assign in_ready = r_in_ready;
  assign c_valid  = r_c_valid;
  assign c_data   = {{3{r_acc[4]}}, r_acc};
  assign c_idx    = r_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
